// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory port and
// hands {inst, inst_pc, inst_pc_plus4} to decode over valid/ready, with redirect support.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] inst_pc_plus4_q, inst_pc_plus4_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;
    logic        unused_ok;

    assign pc_plus4         = pc_q + 32'd4;
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign unused_ok        = ^redirect_pc[1:0];

    // Handshakes: memory transfers when imem_req & imem_ack; decode consumes
    // when inst_valid & inst_ready. A redirect suppresses the decode handshake.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        req_addr_d      = req_addr_q;
        inst_d          = inst_q;
        inst_pc_d       = inst_pc_q;
        inst_pc_plus4_d = inst_pc_plus4_q;
        imem_req        = 1'b0;
        imem_addr       = pc_q;
        inst_valid      = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    // An un-acked request cannot be withdrawn; wait it out in DRAIN.
                    state_d = imem_ack ? S_FETCH : S_DRAIN;
                end else if (imem_ack) begin
                    inst_d          = imem_rdata;
                    inst_pc_d       = pc_q;
                    inst_pc_plus4_d = pc_plus4;
                    pc_d            = pc_plus4;
                    state_d         = S_VALID;
                end
            end
            S_VALID: begin
                inst_valid = !redirect_valid;
                if (redirect_valid) begin
                    state_d = S_FETCH;
                end else if (inst_ready) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        inst_d          = imem_rdata;
                        inst_pc_d       = pc_q;
                        inst_pc_plus4_d = pc_plus4;
                        pc_d            = pc_plus4;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = req_addr_q;
                if (imem_ack) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        if (redirect_valid) begin
            pc_d = redirect_aligned;
        end
        if (imem_req && (state_q != S_DRAIN)) begin
            req_addr_d = imem_addr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_BOOT;
            pc_q            <= RESET_PC;
            req_addr_q      <= RESET_PC;
            inst_q          <= 32'd0;
            inst_pc_q       <= 32'd0;
            inst_pc_plus4_q <= 32'd4;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            req_addr_q      <= req_addr_d;
            inst_q          <= inst_d;
            inst_pc_q       <= inst_pc_d;
            inst_pc_plus4_q <= inst_pc_plus4_d;
        end
    end

    assign inst          = inst_q;
    assign opcode        = inst_q[31:26];
    assign inst_pc       = inst_pc_q;
    assign inst_pc_plus4 = inst_pc_plus4_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: random-latency memory model plus an in-order
// program-stream reference (next expected PC, redirect resets it).
module tb_instruction_fetch;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .opcode         (opcode),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // memory model state
    int          wmin = 0;
    int          wmax = 0;
    logic        pend_active = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    int          pend_wait = 0;

    // reference stream state
    logic [31:0] exp_pc = 32'd0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc = 32'd0;
    logic [31:0] prev_inst = 32'd0;
    int          cyc = 0;
    int          last_hs_cyc = 0;
    int          hs_gap = 0;
    logic        hs_now = 1'b0;

    // sampled outputs of the most recent cycle
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_inst;
    logic [5:0]  s_op;
    logic [31:0] s_pc;
    logic [31:0] s_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend_active = 1'b0;
        prev_hold   = 1'b0;
        exp_pc      = 32'h0000_0000;
        last_hs_cyc = cyc;
    endtask

    // One clock cycle: drive inputs, answer memory, sample and check, advance.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic was_pend;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        was_pend = pend_active;
        if (imem_req) begin
            if (!pend_active) begin
                pend_active = 1'b1;
                pend_addr   = imem_addr;
                pend_wait   = $urandom_range(wmax, wmin);
            end
            imem_ack   = (pend_wait == 0);
            imem_rdata = mem_word(pend_addr);
        end else begin
            imem_ack   = 1'($urandom_range(1, 0));
            imem_rdata = $urandom;
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = inst_valid;
        s_inst  = inst;
        s_op    = opcode;
        s_pc    = inst_pc;
        s_pc4   = inst_pc_plus4;
        hs_now  = 1'b0;

        check("addr_align", s_addr & 32'h3, 32'h0);
        if (s_req && was_pend) check("addr_stable", s_addr, pend_addr);
        if (rv) check("redirect_kills_valid", {31'd0, s_valid}, 32'd0);
        if (prev_hold && !rv) begin
            check("hold_valid", {31'd0, s_valid}, 32'd1);
            check("hold_pc", s_pc, prev_pc);
            check("hold_inst", s_inst, prev_inst);
        end
        if (s_valid) begin
            check("pc_plus4", s_pc4, s_pc + 32'd4);
            check("opcode", {26'd0, s_op}, {26'd0, s_inst[31:26]});
            if (!rdy) check("stall_no_req", {31'd0, s_req}, 32'd0);
            if (rdy) begin
                check("seq_pc", s_pc, exp_pc);
                check("seq_inst", s_inst, mem_word(exp_pc));
                exp_pc      = exp_pc + 32'd4;
                hs_now      = 1'b1;
                hs_gap      = cyc - last_hs_cyc;
                last_hs_cyc = cyc;
            end
        end
        if (rv) exp_pc = {rpc[31:2], 2'b00};
        if (cyc - last_hs_cyc > 100) begin
            check("liveness_gap", 32'(cyc - last_hs_cyc), 32'd100);
            last_hs_cyc = cyc;
        end

        prev_hold = s_valid && !rdy && !rv;
        prev_pc   = s_pc;
        prev_inst = s_inst;
        if (s_req) begin
            if (imem_ack) pend_active = 1'b0;
            else pend_wait--;
        end else begin
            pend_active = 1'b0;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 32'd0);
            if (s_valid) break;
        end
        check("wait_valid", {31'd0, s_valid}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin
        int n_hs;
        reset_n        = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0000_0000);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_opcode", {26'd0, opcode}, 32'd0);
        check("rst_pc", inst_pc, 32'd0);
        check("rst_pc4", inst_pc_plus4, 32'd4);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;

        // zero-wait streaming with a 3-cycle stall at pc 8
        wmin = 0; wmax = 0;
        step(1'b1, 1'b0, 32'd0);
        check("c0_req", {31'd0, s_req}, 32'd0);
        check("c0_valid", {31'd0, s_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("c1_req", {31'd0, s_req}, 32'd1);
        check("c1_addr", s_addr, 32'd0);
        check("c1_valid", {31'd0, s_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("c2_valid", {31'd0, s_valid}, 32'd1);
        check("c2_pc", s_pc, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("c3_pc", s_pc, 32'd4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0);
            check("bp_valid", {31'd0, s_valid}, 32'd1);
            check("bp_pc", s_pc, 32'd8);
            check("bp_req", {31'd0, s_req}, 32'd0);
        end
        step(1'b1, 1'b0, 32'd0);
        check("bp_release_pc", s_pc, 32'd8);
        check("bp_release_req", {31'd0, s_req}, 32'd1);
        check("bp_release_addr", s_addr, 32'd12);
        step(1'b1, 1'b0, 32'd0);
        check("c8_pc", s_pc, 32'd12);

        // two wait cycles per ack: one instruction every 3 cycles
        wmin = 2; wmax = 2;
        n_hs = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 32'd0);
            if (hs_now) begin
                n_hs++;
                if (n_hs >= 2) check("wait2_gap", 32'(hs_gap), 32'd3);
            end
        end
        check("wait2_count", 32'(n_hs), 32'd4);

        // redirect from VALID to an unaligned target
        wmin = 0; wmax = 0;
        wait_valid();
        step(1'b1, 1'b1, 32'h0000_0103);
        check("rv_req", {31'd0, s_req}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("rv_fetch_req", {31'd0, s_req}, 32'd1);
        check("rv_fetch_addr", s_addr, 32'h0000_0100);
        step(1'b1, 1'b0, 32'd0);
        check("rv_valid", {31'd0, s_valid}, 32'd1);
        check("rv_pc", s_pc, 32'h0000_0100);

        // redirect during a stalled fetch, then again during the drain
        step(1'b1, 1'b1, 32'h0000_0020);
        wmin = 3; wmax = 3;
        step(1'b1, 1'b1, 32'h0000_0300);
        check("dr_fetch_addr", s_addr, 32'h0000_0020);
        check("dr_fetch_req", {31'd0, s_req}, 32'd1);
        step(1'b1, 1'b1, 32'h0000_0200);
        check("dr_drain_addr", s_addr, 32'h0000_0020);
        check("dr_drain_valid", {31'd0, s_valid}, 32'd0);
        wmin = 0; wmax = 0;
        step(1'b1, 1'b0, 32'd0);
        check("dr_drain_addr2", s_addr, 32'h0000_0020);
        step(1'b1, 1'b0, 32'd0);
        check("dr_drain_ack_valid", {31'd0, s_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("dr_new_addr", s_addr, 32'h0000_0200);
        check("dr_new_valid", {31'd0, s_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("dr_first_valid", {31'd0, s_valid}, 32'd1);
        check("dr_first_pc", s_pc, 32'h0000_0200);

        // PC wrap at the top of the address space
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("wrap_pc0", s_pc, 32'hFFFF_FFF8);
        step(1'b1, 1'b0, 32'd0);
        check("wrap_pc1", s_pc, 32'hFFFF_FFFC);
        check("wrap_pc1_plus4", s_pc4, 32'h0000_0000);
        step(1'b1, 1'b0, 32'd0);
        check("wrap_pc2", s_pc, 32'h0000_0000);

        // randomized traffic
        wmin = 0; wmax = 3;
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(9, 0) < 7), ($urandom_range(19, 0) == 0), $urandom);
        end

        // asynchronous reset while a fetch is waiting
        wmin = 0; wmax = 0;
        wait_valid();
        wmin = 5; wmax = 5;
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("pre_rst_req", {31'd0, s_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("mid_rst_addr", imem_addr, 32'h0000_0000);
        check("mid_rst_pc", inst_pc, 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        wmin = 0; wmax = 0;
        step(1'b1, 1'b0, 32'd0);
        check("rr_c0_req", {31'd0, s_req}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("rr_c1_addr", s_addr, 32'h0000_0000);
        step(1'b1, 1'b0, 32'd0);
        check("rr_c2_valid", {31'd0, s_valid}, 32'd1);
        check("rr_c2_pc", s_pc, 32'h0000_0000);
        step(1'b1, 1'b0, 32'd0);
        check("rr_c3_pc", s_pc, 32'h0000_0004);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
